// File: rtl/uart_frame_loader.sv
// uart_frame_loader
// Decodes SOF / NUM_FIELDS payload bytes / [checksum] / EOF frames from a UART
// byte stream, range-checks every field and publishes all fields at once with a
// one-cycle o_load pulse. Discarded frames raise a one-cycle o_err with a cause:
// 0 range, 1 checksum, 2 framing, 3 inter-byte timeout.
// Build option: define UART_FRAME_CHECKSUM_EN to expect an XOR-of-payload byte
// between the last field and EOF.
module uart_frame_loader #(
  parameter int unsigned               NUM_FIELDS  = 2,
  parameter int unsigned               FIELD_W     = 6,
  parameter logic [NUM_FIELDS*8-1:0]   FIELD_MAX   = {8'd59, 8'd23},
  parameter logic [7:0]                SOF_BYTE    = 8'hFF,
  parameter logic [7:0]                EOF_BYTE    = 8'hFF,
  parameter int unsigned               TIMEOUT_CYC = 100000
) (
  input  logic                          i_clock,
  input  logic                          reset,
  input  logic                          i_rx_dv,
  input  logic [7:0]                    i_rx_byte,
  output logic [NUM_FIELDS*FIELD_W-1:0] o_fields,
  output logic                          o_load,
  output logic                          o_err,
  output logic [1:0]                    o_err_code,
  output logic                          o_busy
);

  localparam int unsigned IDX_W = (NUM_FIELDS > 1) ? $clog2(NUM_FIELDS) : 1;
  localparam int unsigned CNT_W = (TIMEOUT_CYC > 0) ? $clog2(TIMEOUT_CYC + 1) : 1;
  // Expiry is decided on the idle cycle that would bring the count to TIMEOUT_CYC,
  // so the pulse is registered on that same edge.
  localparam logic [CNT_W-1:0] CNT_LAST = (TIMEOUT_CYC > 0) ? CNT_W'(TIMEOUT_CYC - 1) : '0;
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_FIELDS - 1);

  localparam logic [1:0] ERR_RANGE   = 2'd0;
  localparam logic [1:0] ERR_CSUM    = 2'd1;
  localparam logic [1:0] ERR_FRAMING = 2'd2;
  localparam logic [1:0] ERR_TIMEOUT = 2'd3;

  typedef enum logic [1:0] {
    S_IDLE,
    S_FIELD,
`ifdef UART_FRAME_CHECKSUM_EN
    S_CHK,
`endif
    S_EOF
  } state_t;

  state_t                          state_q, state_d;
  logic [NUM_FIELDS*FIELD_W-1:0]   shadow_q;
  logic [IDX_W-1:0]                idx_q;
  logic [CNT_W-1:0]                cnt_q;
  logic                            load_d, err_d;
  logic [1:0]                      code_d;
  logic                            sof_hit, in_range, last_field, eof_ok, timeout_hit;
  logic                            csum_ok;

`ifdef UART_FRAME_CHECKSUM_EN
  logic [7:0] csum_q;
  assign csum_ok = (i_rx_byte == csum_q);
`else
  assign csum_ok = 1'b0;
`endif

  assign sof_hit     = (i_rx_byte == SOF_BYTE);
  assign eof_ok      = (i_rx_byte == EOF_BYTE);
  assign in_range    = (i_rx_byte <= FIELD_MAX[8*idx_q +: 8]) &&
                       ((i_rx_byte >> FIELD_W) == 8'd0);
  assign last_field  = (idx_q == IDX_LAST);
  // A byte arriving in the expiry cycle takes precedence over the timeout.
  assign timeout_hit = (TIMEOUT_CYC != 0) && (state_q != S_IDLE) &&
                       !i_rx_dv && (cnt_q == CNT_LAST);
  assign o_busy      = (state_q != S_IDLE);

  // State register.
  always_ff @(posedge i_clock or negedge reset) begin
    if (!reset) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // Next-state decode: every deciding byte or an expiry returns to IDLE except
  // accepted fields and a matching checksum.
  always_comb begin
    state_d = state_q;
    if (i_rx_dv) begin
      case (state_q)
        S_IDLE:  if (sof_hit) state_d = S_FIELD;
        S_FIELD: begin
          if (!in_range) state_d = S_IDLE;
`ifdef UART_FRAME_CHECKSUM_EN
          else if (last_field) state_d = S_CHK;
`else
          else if (last_field) state_d = S_EOF;
`endif
        end
`ifdef UART_FRAME_CHECKSUM_EN
        S_CHK:   state_d = csum_ok ? S_EOF : S_IDLE;
`endif
        S_EOF:   state_d = S_IDLE;
        default: state_d = S_IDLE;
      endcase
    end else if (timeout_hit) begin
      state_d = S_IDLE;
    end
  end

  // Output decode: next values of the registered load/error pulses and cause.
  always_comb begin
    load_d = 1'b0;
    err_d  = 1'b0;
    code_d = ERR_RANGE;
    if (i_rx_dv) begin
      case (state_q)
        S_FIELD: if (!in_range) begin
          err_d  = 1'b1;
          code_d = ERR_RANGE;
        end
`ifdef UART_FRAME_CHECKSUM_EN
        S_CHK: if (!csum_ok) begin
          err_d  = 1'b1;
          code_d = ERR_CSUM;
        end
`endif
        S_EOF: begin
          if (eof_ok) begin
            load_d = 1'b1;
          end else begin
            err_d  = 1'b1;
            code_d = ERR_FRAMING;
          end
        end
        default: ;
      endcase
    end else if (timeout_hit) begin
      err_d  = 1'b1;
      code_d = ERR_TIMEOUT;
    end
  end

  // Shadow fields, field index and registered outputs; o_fields moves only on a good EOF.
  always_ff @(posedge i_clock or negedge reset) begin
    if (!reset) begin
      shadow_q   <= '0;
      idx_q      <= '0;
      o_fields   <= '0;
      o_load     <= 1'b0;
      o_err      <= 1'b0;
      o_err_code <= '0;
    end else begin
      o_load     <= load_d;
      o_err      <= err_d;
      o_err_code <= code_d;
      if (load_d) o_fields <= shadow_q;
      if (i_rx_dv && (state_q == S_IDLE) && sof_hit) idx_q <= '0;
      if (i_rx_dv && (state_q == S_FIELD) && in_range) begin
        shadow_q[FIELD_W*idx_q +: FIELD_W] <= i_rx_byte[FIELD_W-1:0];
        if (!last_field) idx_q <= idx_q + 1'b1;
      end
    end
  end

`ifdef UART_FRAME_CHECKSUM_EN
  // XOR accumulator over accepted payload bytes, cleared on SOF.
  always_ff @(posedge i_clock or negedge reset) begin
    if (!reset) begin
      csum_q <= '0;
    end else if (i_rx_dv) begin
      if ((state_q == S_IDLE) && sof_hit)         csum_q <= '0;
      else if ((state_q == S_FIELD) && in_range)  csum_q <= csum_q ^ i_rx_byte;
    end
  end
`endif

  // Inter-byte idle counter: runs only inside a frame, cleared by any byte or expiry.
  always_ff @(posedge i_clock or negedge reset) begin
    if (!reset) begin
      cnt_q <= '0;
    end else if ((TIMEOUT_CYC == 0) || (state_q == S_IDLE) || i_rx_dv || timeout_hit) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

endmodule

// File: tb/tb_uart_frame_loader.sv
// Testbench for uart_frame_loader: directed test-plan scenarios followed by
// randomized frames, all checked cycle by cycle against a byte-level model.
// Honours UART_FRAME_CHECKSUM_EN when the bundle is built with it.
module tb_uart_frame_loader;

  localparam int NF = 2;
  localparam int FW = 6;
  localparam int TO = 10;
`ifdef UART_FRAME_CHECKSUM_EN
  localparam bit CSUM = 1'b1;
`else
  localparam bit CSUM = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              rst_n;
  logic              rx_dv;
  logic [7:0]        rx_byte;
  logic [NF*FW-1:0]  fields;
  logic              load;
  logic              err;
  logic [1:0]        code;
  logic              busy;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  uart_frame_loader #(
    .TIMEOUT_CYC(TO)
  ) dut (
    .i_clock   (clk),
    .reset     (rst_n),
    .i_rx_dv   (rx_dv),
    .i_rx_byte (rx_byte),
    .o_fields  (fields),
    .o_load    (load),
    .o_err     (err),
    .o_err_code(code),
    .o_busy    (busy)
  );

  // Reference model: frame position counted in bytes, plain integer fields.
  int lim [NF] = '{23, 59};
  bit m_active;
  int m_pos, m_sum, m_idle;
  int m_shadow [NF];
  int m_pub [NF];
  bit e_load, e_err;
  int e_code;

  task automatic model_reset();
    m_active = 1'b0;
    m_pos = 0; m_sum = 0; m_idle = 0;
    for (int i = 0; i < NF; i++) begin
      m_shadow[i] = 0;
      m_pub[i] = 0;
    end
  endtask

  task automatic model_fail(input int c);
    e_err = 1'b1;
    e_code = c;
    m_active = 1'b0;
    m_idle = 0;
  endtask

  task automatic model_step(input bit dv, input int b);
    e_load = 1'b0; e_err = 1'b0; e_code = 0;
    if (!m_active) begin
      if (dv && b == 8'hFF) begin
        m_active = 1'b1; m_pos = 0; m_sum = 0; m_idle = 0;
      end
    end else if (!dv) begin
      m_idle++;
      if (m_idle == TO) model_fail(3);
    end else begin
      m_idle = 0;
      if (m_pos < NF) begin
        if (b > lim[m_pos] || b >= (1 << FW)) model_fail(0);
        else begin
          m_shadow[m_pos] = b;
          m_sum = m_sum ^ b;
          m_pos++;
        end
      end else if (CSUM && m_pos == NF) begin
        if (b == m_sum) m_pos++;
        else model_fail(1);
      end else if (b == 8'hFF) begin
        for (int i = 0; i < NF; i++) m_pub[i] = m_shadow[i];
        e_load = 1'b1;
        m_active = 1'b0;
      end else begin
        model_fail(2);
      end
    end
  endtask

  function automatic logic [NF*FW-1:0] model_fields();
    int acc = 0;
    for (int i = 0; i < NF; i++) acc += m_pub[i] * (1 << (FW * i));
    return (NF*FW)'(acc);
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    checks++;
    assert (got === want) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, got, want);
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".load"},   32'(load),   32'(e_load));
    chk({tag, ".err"},    32'(err),    32'(e_err));
    if (e_err) chk({tag, ".code"}, 32'(code), 32'(e_code));
    chk({tag, ".fields"}, 32'(fields), 32'(model_fields()));
    chk({tag, ".busy"},   32'(busy),   32'(m_active));
  endtask

  task automatic step(input bit dv, input int b, input string tag);
    @(negedge clk);
    rx_dv = dv;
    rx_byte = 8'(b);
    @(posedge clk);
    #1;
    model_step(dv, b);
    check_all(tag);
  endtask

  task automatic idle(input int n, input string tag);
    for (int i = 0; i < n; i++) step(1'b0, 0, tag);
  endtask

  initial begin
    int q[$];
    int v, s, gap;

    rst_n = 1'b0; rx_dv = 1'b0; rx_byte = 8'h00;
    model_reset();
    #12;
    e_load = 1'b0; e_err = 1'b0; e_code = 0;
    check_all("reset");
    chk("reset.code", 32'(code), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Basic frame: fields 12 and 30.
    step(1, 8'hFF, "f1.sof");
    step(1, 8'h0C, "f1.b0");
    step(1, 8'h1E, "f1.b1");
    if (CSUM) step(1, 8'h12, "f1.ck");
    step(1, 8'hFF, "f1.eof");
    chk("f1.load_now", 32'(load), 32'd1);
    chk("f1.value", 32'(fields), 32'h78C);
    step(0, 0, "f1.after");
    chk("f1.load_1cyc", 32'(load), 32'd0);

    // Out-of-range field 0 (24 > 23), then a valid frame.
    step(1, 8'hFF, "rng.sof");
    step(1, 8'h18, "rng.b0");
    chk("rng.err", 32'(err), 32'd1);
    chk("rng.code", 32'(code), 32'd0);
    chk("rng.hold", 32'(fields), 32'h78C);
    step(1, 8'hFF, "ok.sof");
    step(1, 8'h05, "ok.b0");
    step(1, 8'h10, "ok.b1");
    if (CSUM) step(1, 8'h15, "ok.ck");
    step(1, 8'hFF, "ok.eof");
    chk("ok.value", 32'(fields), 32'h405);

    // Bad EOF byte.
    step(1, 8'hFF, "frm.sof");
    step(1, 8'h05, "frm.b0");
    step(1, 8'h10, "frm.b1");
    if (CSUM) step(1, 8'h15, "frm.ck");
    step(1, 8'h00, "frm.eof");
    chk("frm.code", 32'(code), 32'd2);
    chk("frm.busy", 32'(busy), 32'd0);

    // Timeout after exactly TO idle cycles.
    step(1, 8'hFF, "to.sof");
    step(1, 8'h05, "to.b0");
    idle(TO - 1, "to.wait");
    chk("to.early", 32'(err), 32'd0);
    step(0, 0, "to.expire");
    chk("to.err", 32'(err), 32'd1);
    chk("to.code", 32'(code), 32'd3);

    // A byte on the expiry cycle wins.
    step(1, 8'hFF, "tw.sof");
    step(1, 8'h05, "tw.b0");
    idle(TO - 1, "tw.wait");
    step(1, 8'h10, "tw.b1");
    chk("tw.noerr", 32'(err), 32'd0);
    chk("tw.busy", 32'(busy), 32'd1);
    if (CSUM) step(1, 8'h15, "tw.ck");
    step(1, 8'hFF, "tw.eof");
    chk("tw.load", 32'(load), 32'd1);

`ifdef UART_FRAME_CHECKSUM_EN
    // Wrong checksum byte.
    step(1, 8'hFF, "ck.sof");
    step(1, 8'h0C, "ck.b0");
    step(1, 8'h1E, "ck.b1");
    step(1, 8'h13, "ck.bad");
    chk("ck.code", 32'(code), 32'd1);
`endif

    // Asynchronous reset mid-frame.
    step(1, 8'hFF, "ar.sof");
    step(1, 8'h0C, "ar.b0");
    @(negedge clk);
    rx_dv = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    e_load = 1'b0; e_err = 1'b0; e_code = 0;
    check_all("ar.async");
    chk("ar.code", 32'(code), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    step(1, 8'hFF, "ar2.sof");
    step(1, 8'h0C, "ar2.b0");
    step(1, 8'h1E, "ar2.b1");
    if (CSUM) step(1, 8'h12, "ar2.ck");
    step(1, 8'hFF, "ar2.eof");
    chk("ar2.value", 32'(fields), 32'h78C);

    // Randomized frames with occasional corruption, junk and long gaps.
    repeat (60) begin
      q.delete();
      if ($urandom_range(0, 3) == 0) q.push_back($urandom_range(0, 255));
      q.push_back(8'hFF);
      s = 0;
      for (int i = 0; i < NF; i++) begin
        v = ($urandom_range(0, 9) == 0) ? $urandom_range(0, 255) : $urandom_range(0, lim[i]);
        s = s ^ v;
        q.push_back(v);
      end
      if (CSUM) q.push_back(($urandom_range(0, 9) == 0) ? (s ^ $urandom_range(1, 255)) : s);
      q.push_back(($urandom_range(0, 9) == 0) ? $urandom_range(0, 254) : 8'hFF);
      foreach (q[k]) begin
        gap = ($urandom_range(0, 6) == 0) ? $urandom_range(TO - 2, TO + 1) : $urandom_range(0, 1);
        idle(gap, "rnd.gap");
        step(1, q[k], "rnd.byte");
      end
    end
    idle(TO + 2, "rnd.flush");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_frame_loader.md
# uart_frame_loader

- Parametrised frame decoder between the `uart` byte receiver and the clock/alarm time registers.
- Consumes the received byte stream and recognises `SOF`, then `NUM_FIELDS` payload bytes, an optional checksum byte, then `EOF`.
- Range-checks every field and publishes all fields atomically with a one-cycle load pulse.
- Reports malformed, out-of-range, checksum-failed or stalled frames on an error pulse with a cause code.

## Interface

Parameters:
- `NUM_FIELDS`, 2: payload bytes per frame; field 0 is the first byte after SOF. Range 1..8.
- `FIELD_W`, 6: stored bits per field. Range 1..8.
- `FIELD_MAX`, {8'd59, 8'd23}: packed `NUM_FIELDS*8` bits; byte i (bits [8i+7:8i]) is the inclusive maximum for field i.
- `SOF_BYTE`, 8'hFF: start marker.
- `EOF_BYTE`, 8'hFF: end marker.
- `TIMEOUT_CYC`, 100000: idle cycles allowed between bytes inside a frame; 0 disables the timeout.

Ports:
- `i_clock`  in  1: single clock, rising edge.
- `reset`  in  1: asynchronous, active-low reset.
- `i_rx_dv`  in  1: byte valid; every cycle high delivers one byte.
- `i_rx_byte`  in  8: received byte, qualified by `i_rx_dv`.
- `o_fields`  out  NUM_FIELDS*FIELD_W: published fields; field i is at [FIELD_W*i+FIELD_W-1 : FIELD_W*i].
- `o_load`  out  1: one-cycle pulse; `o_fields` has just been updated.
- `o_err`  out  1: one-cycle pulse; frame discarded.
- `o_err_code`  out  2: cause, valid while `o_err`=1: 0 range, 1 checksum, 2 framing, 3 timeout.
- `o_busy`  out  1: high when the state is not IDLE.

## Operation

- Reset (`reset`=0) forces:
  - state IDLE;
  - `o_fields`, shadow fields, field index, checksum accumulator and timeout counter to 0;
  - `o_load`=0, `o_err`=0, `o_err_code`=0, `o_busy`=0.
- IDLE:
  - a byte equal to `SOF_BYTE` clears the index and checksum, then goes to FIELD;
  - all other bytes are ignored silently, with no error.
- FIELD, on each byte:
  - if the byte is greater than `FIELD_MAX[idx]`, or any bit at or above `FIELD_W` is set, pulse `o_err` with code 0 and go to IDLE;
  - otherwise store `byte[FIELD_W-1:0]` into shadow[idx] and XOR the byte into the checksum;
  - when idx equals `NUM_FIELDS-1`, go to CHK (macro defined) or EOF; otherwise increment idx.
- CHK:
  - a byte equal to the accumulated XOR goes to EOF;
  - any other byte pulses `o_err` with code 1 and goes to IDLE.
- EOF:
  - a byte equal to `EOF_BYTE` copies all shadow fields to `o_fields`, pulses `o_load` and goes to IDLE;
  - any other byte pulses `o_err` with code 2 and goes to IDLE.
- Timeout:
  - outside IDLE, the counter increments on every cycle with `i_rx_dv`=0 and clears on every byte;
  - when the counter reaches `TIMEOUT_CYC`, pulse `o_err` with code 3, go to IDLE and clear the counter.
- `o_fields` changes only on a successful EOF. Failed frames never alter it, so partial updates are impossible.
- An SOF value received inside a frame has no special meaning: it is treated as data, and the range check rejects it with default limits.

## Timing

- `o_load`, `o_err`, `o_err_code` and `o_fields` are registered.
- They change on the rising edge that samples the deciding byte, so they are visible the cycle after `i_rx_dv`.
- Each of `o_load` and `o_err` is exactly 1 cycle wide. They are never high together.
- Back-to-back bytes are accepted on consecutive cycles.
- An SOF arriving in the cycle immediately after EOF is accepted as the start of a new frame.
- If a byte and timeout expiry fall in the same cycle, the byte wins and no timeout is raised.
- If reset is asserted mid-frame, the partial frame is lost and `o_fields` returns to 0.
- The timeout counter width is `$clog2(TIMEOUT_CYC+1)`, with a minimum of 1.
- Frame length is 2+`NUM_FIELDS` bytes without the checksum, and 3+`NUM_FIELDS` with it.

## Configuration

- `UART_FRAME_CHECKSUM_EN`, defined:
  - the CHK state exists;
  - frames carry an XOR-of-payload byte between the last field and EOF;
  - error code 1 is reachable.
- Not defined:
  - no CHK state, no accumulator logic;
  - EOF follows the last field directly;
  - code 1 is never produced.

## Test plan

All scenarios use default parameters and macro off unless noted.

- Stimulus: bytes FF, 0x0C, 0x1E, FF. Required: one `o_load` pulse 1 cycle after the last byte; `o_fields` = {6'd30, 6'd12}; `o_err` stays 0.
- Stimulus: bytes FF, 0x18 (24 > 23). Required: `o_err`=1 with code 0 on the cycle after 0x18; `o_fields` unchanged; the following valid frame loads normally.
- Stimulus: bytes FF, 0x05, 0x10, 0x00. Required: `o_err` with code 2; `o_busy` returns to 0.
- Stimulus: `TIMEOUT_CYC`=10; bytes FF, 0x05, then silence. Required: `o_err` with code 3 exactly 10 idle cycles after 0x05; a byte on the 10th idle cycle suppresses the timeout.
- Stimulus: macro defined; bytes FF, 0x0C, 0x1E, 0x12, FF. Required: load. Same frame with checksum 0x13: `o_err` with code 1.
- Stimulus: reset pulsed low after FF, 0x0C. Required: all outputs read 0 asynchronously; the next full frame loads correctly.
